icache_l1: RTL and testbench
============================

ICACHE_L1 -- requirements
Module: icache_l1

Interface
REQ-001 Parameter LINES, default 64, number of cache lines; SHALL be a power of two >= 2.
REQ-002 Parameter WORDS_PER_LINE, default 4, 32-bit words per line; SHALL be a power of two >= 2.
REQ-003 clk  input  1  clock; one clock domain, all state updates on posedge clk.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 req_valid  input  1  fetch request present.
REQ-006 req_pc  input  32  fetch byte address; bits [1:0] ignored.
REQ-007 req_ready  output  1  request accepted this cycle when req_valid & req_ready.
REQ-008 resp_valid  output  1  resp_instr holds the instruction for the oldest accepted request; single-cycle pulse, no backpressure.
REQ-009 resp_instr  output  32  fetched instruction word.
REQ-010 flush  input  1  invalidate entire cache.
REQ-011 bus_addr  output  32  word-aligned refill address.
REQ-012 bus_ren  output  1  refill read request; held until bus_done.
REQ-013 bus_rdata  input  32  refill read data, valid when bus_done.
REQ-014 bus_done  input  1  completes the current bus read.

Function
REQ-015 Direct-mapped; OFF = 2+log2(WORDS_PER_LINE), IDX = log2(LINES); word = req_pc[OFF-1:2], index = req_pc[OFF+IDX-1:OFF], tag = req_pc[31:OFF+IDX].
REQ-016 States: IDLE, LOOKUP, REFILL, RESPOND.
REQ-017 req_ready = ~flush & (state==IDLE | (state==LOOKUP & hit)); accepted request registers req_pc and synchronously reads tag/data arrays, next state LOOKUP.
REQ-018 LOOKUP hit (valid[index] & tag match): resp_valid=1, resp_instr=data word this cycle (hit latency 1 cycle after acceptance); next state LOOKUP if a new request is accepted that cycle, else IDLE; sustained hits give 1 response/cycle.
REQ-019 LOOKUP miss: resp_valid=0, word counter cleared, next state REFILL.
REQ-020 REFILL: bus_ren=1, bus_addr = {tag, index, counter, 2'b00}, starting at word 0; on bus_done write bus_rdata to data[index][counter], increment counter; bus_addr/bus_ren stable while bus_done=0.
REQ-021 After last word's bus_done: write tag, set valid[index], next state RESPOND.
REQ-022 RESPOND: resp_valid=1 with requested word from freshly filled line; req_ready=0; next state IDLE.
REQ-023 bus_ren=0 and bus_addr=0 outside REFILL.
REQ-024 flush clears all valid bits in the same edge (single cycle), regardless of state.
REQ-025 flush in LOOKUP: no resp_valid, next state IDLE; flush in RESPOND: resp_valid suppressed, next IDLE.
REQ-026 flush in REFILL: current beat completes (bus_ren held until bus_done), data discarded, valid not set, no response, then IDLE.
REQ-027 flush with req_valid in IDLE: request not accepted.
REQ-028 Refill completion and flush on the same edge: flush wins, line left invalid, no response.

Reset
REQ-029 rst asserted: state IDLE, all valid bits 0, counter 0, req_ready=0, resp_valid=0, resp_instr=0, bus_ren=0, bus_addr=0, on the next edge.
REQ-030 rst mid-REFILL abandons the bus transaction immediately (bus_ren=0 next cycle); tag/data arrays not required to be cleared.
REQ-031 req_ready first asserts in the cycle after rst deasserts.

Configuration
REQ-032 Macro ICACHE_STATS_EN defined: outputs stat_hits[31:0] and stat_misses[31:0] exist; increment on each LOOKUP hit/miss respectively, wrap at 2^32, cleared by rst, not by flush.
REQ-033 ICACHE_STATS_EN undefined: stat ports and counters absent; all other behaviour identical.

Verification
REQ-034 Cold miss: defaults, req_pc=0x0000_0108, bus_done one cycle after each bus_ren -> bus_addr 0x100,0x104,0x108,0x10C in order; RESPOND resp_instr = word from 0x108; stat_misses=1.
REQ-035 Hit stream: after line 0x100 filled, requests 0x100,0x104,0x108,0x10C back-to-back -> req_ready held 1, four consecutive resp_valid cycles, no bus_ren, stat_hits=4.
REQ-036 Conflict: fill 0x100, then request 0x500 (same index 16, different tag) -> miss, refill 0x500-0x50C; then 0x100 misses again.
REQ-037 Flush mid-refill: flush during second beat with bus_done delayed 3 cycles -> bus_ren held until bus_done, no resp_valid, IDLE; re-request 0x100 misses.
REQ-038 Reset mid-refill: rst during REFILL -> bus_ren=0, resp_valid=0 next cycle; prior-filled line misses after reset.
REQ-039 Simultaneous: flush on the edge the last refill beat completes -> no resp_valid; same address next request misses.

Source files
------------

// File: rtl/icache_l1.sv
// Direct-mapped L1 instruction cache with word-by-word bus refill; optional ICACHE_STATS_EN adds hit/miss counters.
// Latency: a hit responds 1 cycle after acceptance, and a miss responds the cycle after the last refill beat.
// Backpressure: req_ready drops while a miss is refilling; resp has no backpressure; bus_ren is held until bus_done.
module icache_l1 #(
    parameter int LINES          = 64,
    parameter int WORDS_PER_LINE = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    input  logic [31:0] req_pc,
    output logic        req_ready,
    output logic        resp_valid,
    output logic [31:0] resp_instr,
    input  logic        flush,
    output logic [31:0] bus_addr,
    output logic        bus_ren,
    input  logic [31:0] bus_rdata,
    input  logic        bus_done
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] stat_hits,
    output logic [31:0] stat_misses
`endif
);

    localparam int WW  = $clog2(WORDS_PER_LINE);
    localparam int IW  = $clog2(LINES);
    localparam int OFF = 2 + WW;
    localparam int TW  = 32 - OFF - IW;

    typedef enum logic [1:0] {IDLE, LOOKUP, REFILL, RESPOND} state_t;

    state_t state, state_nxt;

    logic [TW-1:0] tag_mem  [0:LINES-1];
    logic [31:0]   data_mem [0:LINES*WORDS_PER_LINE-1];
    logic [LINES-1:0] valid;

    logic [TW-1:0] tag_q, tag_rd;
    logic [IW-1:0] idx_q;
    logic [WW-1:0] word_q, cnt;
    logic [31:0]   data_rd, fill_word;
    logic          flush_pend;

    logic [TW-1:0] req_tag;
    logic [IW-1:0] req_idx;
    logic [WW-1:0] req_word;
    logic          accept, hit, beat, last_beat, discard, fill_commit;
    logic          lookup_hit, lookup_miss;
    logic          unused_pc_lsb;

    assign req_word = req_pc[OFF-1:2];
    assign req_idx  = req_pc[OFF+IW-1:OFF];
    assign req_tag  = req_pc[31:OFF+IW];
    assign unused_pc_lsb = ^req_pc[1:0];

    assign hit         = (state == LOOKUP) && valid[idx_q] && (tag_rd == tag_q);
    assign req_ready   = ~rst & ~flush & ((state == IDLE) | hit);
    assign accept      = req_valid & req_ready;
    assign lookup_hit  = (state == LOOKUP) & ~flush & hit;
    assign lookup_miss = (state == LOOKUP) & ~flush & ~hit;
    assign beat        = (state == REFILL) & bus_done;
    assign last_beat   = beat & (&cnt);
    // A flush seen at any point of the refill poisons the rest of it.
    assign discard     = flush | flush_pend;
    assign fill_commit = last_beat & ~discard;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        resp_valid = 1'b0;
        resp_instr = 32'd0;
        bus_ren    = 1'b0;
        bus_addr   = 32'd0;
        case (state)
            IDLE: begin
                if (accept) state_nxt = LOOKUP;
            end
            LOOKUP: begin
                if (flush) begin
                    state_nxt = IDLE;
                end else if (hit) begin
                    resp_valid = 1'b1;
                    resp_instr = data_rd;
                    state_nxt  = accept ? LOOKUP : IDLE;
                end else begin
                    state_nxt = REFILL;
                end
            end
            REFILL: begin
                bus_ren  = 1'b1;
                bus_addr = {tag_q, idx_q, cnt, 2'b00};
                if (beat && discard) begin
                    state_nxt = IDLE;
                end else if (last_beat) begin
                    state_nxt = RESPOND;
                end
            end
            RESPOND: begin
                if (!flush) begin
                    resp_valid = 1'b1;
                    resp_instr = fill_word;
                end
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid      <= '0;
            cnt        <= '0;
            flush_pend <= 1'b0;
        end else begin
            if (lookup_miss) begin
                cnt        <= '0;
                flush_pend <= 1'b0;
            end
            if (state == REFILL && flush) flush_pend <= 1'b1;
            if (beat) cnt <= cnt + WW'(1);
            if (fill_commit) valid[idx_q] <= 1'b1;
            // Flush is last so it beats a same-edge fill completion.
            if (flush) valid <= '0;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            tag_q   <= req_tag;
            idx_q   <= req_idx;
            word_q  <= req_word;
            tag_rd  <= tag_mem[req_idx];
            data_rd <= data_mem[{req_idx, req_word}];
        end
        if (beat && !discard) data_mem[{idx_q, cnt}] <= bus_rdata;
        if (beat && cnt == word_q) fill_word <= bus_rdata;
        if (fill_commit) tag_mem[idx_q] <= tag_q;
    end

`ifdef ICACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= 32'd0;
            stat_misses <= 32'd0;
        end else begin
            if (lookup_hit)  stat_hits   <= stat_hits + 32'd1;
            if (lookup_miss) stat_misses <= stat_misses + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_icache_l1.sv
// Directed bench for icache_l1: cold miss, hit stream, conflict, flush and reset corner cases.
module tb_icache_l1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic [31:0] req_pc;
    logic        req_ready;
    logic        resp_valid;
    logic [31:0] resp_instr;
    logic        flush;
    logic [31:0] bus_addr;
    logic        bus_ren;
    logic [31:0] bus_rdata;
    logic        bus_done;
`ifdef ICACHE_STATS_EN
    logic [31:0] stat_hits;
    logic [31:0] stat_misses;
`endif

    int tests = 0;
    int fails = 0;

    icache_l1 dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_pc     (req_pc),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_instr (resp_instr),
        .flush      (flush),
        .bus_addr   (bus_addr),
        .bus_ren    (bus_ren),
        .bus_rdata  (bus_rdata),
        .bus_done   (bus_done)
`ifdef ICACHE_STATS_EN
        ,
        .stat_hits  (stat_hits),
        .stat_misses(stat_misses)
`endif
    );

    always #5 clk = ~clk;

    // Backing memory contents: upper half a marker, lower half the byte address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {16'hC0DE, a[15:2], 2'b00};
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic serve_line(input logic [31:0] base, input int delay, input string name);
        for (int w = 0; w < 4; w++) begin
            tests++;
            if (bus_ren !== 1'b1 || bus_addr !== base + 32'(4 * w)) begin
                fails++;
                $display("FAIL %s_beat%0d: bus_ren=%b bus_addr=%h, want 1 / %h",
                         name, w, bus_ren, bus_addr, base + 32'(4 * w));
            end
            repeat (delay) tick();
            if (delay > 0) begin
                tests++;
                if (bus_ren !== 1'b1 || bus_addr !== base + 32'(4 * w)) begin
                    fails++;
                    $display("FAIL %s_stable%0d: bus_ren=%b bus_addr=%h, want 1 / %h",
                             name, w, bus_ren, bus_addr, base + 32'(4 * w));
                end
            end
            bus_done  = 1'b1;
            bus_rdata = mem_word(base + 32'(4 * w));
            tick();
            bus_done  = 1'b0;
            bus_rdata = 32'd0;
            #1;
        end
    endtask

    task automatic fetch_miss(input logic [31:0] pc, input int delay, input string name);
        req_valid = 1'b1;
        req_pc    = pc;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL %s_accept: req_ready=%b want 1", name, req_ready);
        end
        tick();
        req_valid = 1'b0;
        #1;
        tests++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL %s_miss: resp_valid=%b want 0", name, resp_valid);
        end
        tick();
        #1;
        serve_line(pc & 32'hFFFF_FFF0, delay, name);
        tests++;
        if (resp_valid !== 1'b1 || resp_instr !== mem_word(pc)) begin
            fails++;
            $display("FAIL %s_respond: resp_valid=%b instr=%h, want 1 / %h",
                     name, resp_valid, resp_instr, mem_word(pc));
        end
        tick();
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; req_valid = 1'b1; req_pc = 32'h0; flush = 1'b0;
        bus_rdata = 32'd0; bus_done = 1'b0;
        repeat (2) tick();
        #1;
        tests++;
        if (req_ready !== 1'b0 || resp_valid !== 1'b0 || resp_instr !== 32'd0 ||
            bus_ren !== 1'b0 || bus_addr !== 32'd0) begin
            fails++;
            $display("FAIL reset_outputs: rdy=%b rv=%b ri=%h ren=%b addr=%h, want all 0",
                     req_ready, resp_valid, resp_instr, bus_ren, bus_addr);
        end
        req_valid = 1'b0;
        rst = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_release_ready: req_ready=%b want 1", req_ready);
        end
    endtask

    task automatic test_cold_miss;
        fetch_miss(32'h0000_0108, 1, "cold");
        tests++;
        if (resp_valid !== 1'b0 || bus_ren !== 1'b0) begin
            fails++;
            $display("FAIL cold_idle: resp_valid=%b bus_ren=%b want 0 / 0", resp_valid, bus_ren);
        end
`ifdef ICACHE_STATS_EN
        tests++;
        if (stat_misses !== 32'd1) begin
            fails++;
            $display("FAIL cold_stat_misses: got %0d want 1", stat_misses);
        end
`endif
    endtask

    task automatic test_back_to_back;
        req_valid = 1'b1;
        req_pc    = 32'h100;
        #1;
        tests++;
        if (req_ready !== 1'b1) begin
            fails++;
            $display("FAIL hits_accept0: req_ready=%b want 1", req_ready);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            if (i < 4) req_pc = 32'h100 + 32'(4 * i);
            else req_valid = 1'b0;
            #1;
            tests++;
            if (resp_valid !== 1'b1 || resp_instr !== mem_word(32'h100 + 32'(4 * (i - 1))) ||
                bus_ren !== 1'b0 || (i < 4 && req_ready !== 1'b1)) begin
                fails++;
                $display("FAIL hits_resp%0d: rv=%b instr=%h ren=%b rdy=%b, want 1 / %h / 0 / 1",
                         i, resp_valid, resp_instr, bus_ren, req_ready,
                         mem_word(32'h100 + 32'(4 * (i - 1))));
            end
        end
        tick();
        #1;
        tests++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL hits_end: resp_valid=%b want 0", resp_valid);
        end
`ifdef ICACHE_STATS_EN
        tests++;
        if (stat_hits !== 32'd4) begin
            fails++;
            $display("FAIL hits_stat: got %0d want 4", stat_hits);
        end
`endif
    endtask

    task automatic test_conflict;
        fetch_miss(32'h0000_0504, 0, "conflict_500");
        fetch_miss(32'h0000_010C, 1, "conflict_100");
    endtask

    task automatic test_flush_refill;
        req_valid = 1'b1; req_pc = 32'h200;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        #1;
        tests++;
        if (bus_ren !== 1'b1 || bus_addr !== 32'h200) begin
            fails++;
            $display("FAIL flush_beat0: ren=%b addr=%h want 1 / 200", bus_ren, bus_addr);
        end
        bus_done = 1'b1; bus_rdata = mem_word(32'h200);
        tick();
        bus_done = 1'b0;
        flush = 1'b1;
        #1;
        tests++;
        if (bus_ren !== 1'b1 || bus_addr !== 32'h204 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_beat1: ren=%b addr=%h rv=%b want 1 / 204 / 0",
                     bus_ren, bus_addr, resp_valid);
        end
        tick();
        flush = 1'b0;
        for (int d = 0; d < 2; d++) begin
            #1;
            tests++;
            if (bus_ren !== 1'b1 || bus_addr !== 32'h204) begin
                fails++;
                $display("FAIL flush_hold%0d: ren=%b addr=%h want 1 / 204", d, bus_ren, bus_addr);
            end
            tick();
        end
        bus_done = 1'b1; bus_rdata = mem_word(32'h204);
        tick();
        bus_done = 1'b0;
        #1;
        tests++;
        if (bus_ren !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle: ren=%b rv=%b rdy=%b want 0 / 0 / 1",
                     bus_ren, resp_valid, req_ready);
        end
        fetch_miss(32'h0000_0100, 0, "flush_remiss");
    endtask

    task automatic test_reset_refill;
        req_valid = 1'b1; req_pc = 32'h300;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        bus_done = 1'b1; bus_rdata = mem_word(32'h300);
        tick();
        bus_done = 1'b0;
        rst = 1'b1;
        tick();
        #1;
        tests++;
        if (bus_ren !== 1'b0 || resp_valid !== 1'b0 || bus_addr !== 32'd0) begin
            fails++;
            $display("FAIL rst_refill: ren=%b rv=%b addr=%h want 0 / 0 / 0",
                     bus_ren, resp_valid, bus_addr);
        end
        rst = 1'b0;
        #1;
        fetch_miss(32'h0000_0100, 1, "rst_remiss");
    endtask

    task automatic test_flush_last_beat;
        req_valid = 1'b1; req_pc = 32'h408;
        #1;
        tick();
        req_valid = 1'b0;
        tick();
        for (int w = 0; w < 3; w++) begin
            bus_done = 1'b1; bus_rdata = mem_word(32'h400 + 32'(4 * w));
            tick();
        end
        bus_rdata = mem_word(32'h40C);
        flush = 1'b1;
        tick();
        flush = 1'b0; bus_done = 1'b0;
        #1;
        tests++;
        if (resp_valid !== 1'b0 || bus_ren !== 1'b0) begin
            fails++;
            $display("FAIL simul_noresp: rv=%b ren=%b want 0 / 0", resp_valid, bus_ren);
        end
        fetch_miss(32'h0000_0408, 0, "simul_remiss");
    endtask

    task automatic test_flush_idle_lookup;
        req_valid = 1'b1; req_pc = 32'h404; flush = 1'b1;
        #1;
        tests++;
        if (req_ready !== 1'b0) begin
            fails++;
            $display("FAIL flush_idle_block: req_ready=%b want 0", req_ready);
        end
        tick();
        flush = 1'b0;
        #1;
        tests++;
        if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
            fails++;
            $display("FAIL flush_idle_after: rv=%b rdy=%b want 0 / 1", resp_valid, req_ready);
        end
        // 0x404 was invalidated above, so refill it and then flush on its hit.
        req_valid = 1'b0;
        fetch_miss(32'h0000_0404, 0, "flush_lookup_fill");
        req_valid = 1'b1; req_pc = 32'h404;
        #1;
        tick();
        req_valid = 1'b0; flush = 1'b1;
        #1;
        tests++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_lookup: resp_valid=%b want 0", resp_valid);
        end
        tick();
        flush = 1'b0;
        #1;
        tests++;
        if (req_ready !== 1'b1 || resp_valid !== 1'b0) begin
            fails++;
            $display("FAIL flush_lookup_idle: rdy=%b rv=%b want 1 / 0", req_ready, resp_valid);
        end
    endtask

    initial begin
        test_reset();
        test_cold_miss();
        test_back_to_back();
        test_conflict();
        test_flush_refill();
        test_reset_refill();
        test_flush_last_beat();
        test_flush_idle_lookup();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
